// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive-path types and constants
//   rx_state_t : receiver FSM state encoding
//   OVERSAMPLE : s_tick pulses per bit period
//   MID_TICK   : tick index at the middle of the start bit
//   WORD_W     : width of the host-side data word
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;
    localparam int WORD_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_unit_if.sv
// rtl/uart_rx_unit_if.sv - host read/status interface of the UART receiver
//   rd_uart     : host -> unit, pop the head word
//   clr_err     : host -> unit, clear sticky overrun_err
//   r_data      : unit -> host, FIFO head word (zero-extended)
//   rx_empty    : unit -> host, FIFO empty
//   rx_full     : unit -> host, FIFO full
//   frame_err   : unit -> host, one-clk pulse on bad stop bit
//   overrun_err : unit -> host, sticky dropped-word flag
//   parity_err  : unit -> host, one-clk pulse on parity mismatch
//   modport master : host side, modport slave : receiver side
interface uart_rx_unit_if;
    import uart_pkg::*;

    logic              rd_uart;
    logic              clr_err;
    logic [WORD_W-1:0] r_data;
    logic              rx_empty;
    logic              rx_full;
    logic              frame_err;
    logic              overrun_err;
    logic              parity_err;

    modport master (
        output rd_uart, clr_err,
        input  r_data, rx_empty, rx_full, frame_err, overrun_err, parity_err
    );

    modport slave (
        input  rd_uart, clr_err,
        output r_data, rx_empty, rx_full, frame_err, overrun_err, parity_err
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive buffer
//   clk, reset : clock, asynchronous active-high reset
//   wr, w_data : write strobe and word; dropped when full unless rd in same cycle
//   rd         : pop head word; ignored when empty
//   r_data     : head word (mem[rd_ptr])
//   empty/full : occupancy flags
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [WORD_W-1:0] w_data,
    input  logic              rd,
    output logic [WORD_W-1:0] r_data,
    output logic              empty,
    output logic              full
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WORD_W-1:0]     mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_en;
    logic                  rd_en;

    // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign wr_en = wr & (~full | rd);
    assign rd_en = rd & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= w_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign r_data = mem[rd_ptr];
    assign empty  = (count == '0);
    assign full   = (count == (ADDR_WIDTH + 1)'(DEPTH));

endmodule

// File: rtl/uart_rx_unit.sv
// rtl/uart_rx_unit.sv - UART receiver: rx synchroniser, 16x oversampling FSM, FWFT FIFO, error flags
//   clk, reset : clock, asynchronous active-high reset
//   s_tick     : oversampling enable, 16 per bit period
//   rx         : asynchronous serial input, idle high
//   host       : uart_rx_unit_if.slave (rd_uart, clr_err, r_data, rx_empty,
//                rx_full, frame_err, overrun_err, parity_err)
//   Optional even-parity bit: define UART_RX_PARITY_EN.
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int ADDR_WIDTH = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s_tick,
    input  logic           rx,
    uart_rx_unit_if.slave  host
);

    // Tick counter must reach SB_TICK-1 for 1.5/2 stop bits.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    rx_state_t         state;
    logic [SW-1:0]     s;
    logic [2:0]        n;
    logic [DBIT-1:0]   b;
    logic              rx_meta;
    logic              rxs;
    logic              rx_done;
    logic              frame_err_q;
    logic              overrun_q;
    logic              fifo_full;
    logic [WORD_W-1:0] w_word;
`ifdef UART_RX_PARITY_EN
    logic              parity_bad;
    logic              parity_err_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            b           <= '0;
            rx_done     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_done     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == SW'(MID_TICK)) begin
                            // Line high again at mid start bit: treat as a glitch.
                            if (!rxs) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == SW'(OVERSAMPLE - 1)) begin
                            b <= {rxs, b[DBIT-1:1]};
                            s <= '0;
                            if (n == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (s == SW'(OVERSAMPLE - 1)) begin
                            // Even parity: received bit must equal XOR of the data bits.
                            parity_bad <= (rxs != ^b);
                            s          <= '0;
                            state      <= STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (s_tick) begin
                        if (s == SW'(SB_TICK - 1)) begin
                            state       <= IDLE;
                            frame_err_q <= ~rxs;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= parity_bad;
                            rx_done      <= rxs & ~parity_bad;
`else
                            rx_done      <= rxs;
`endif
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_word          = '0;
        w_word[DBIT-1:0] = b;
    end

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (rx_done && fifo_full && !host.rd_uart) begin
            overrun_q <= 1'b1;
        end else if (host.clr_err) begin
            overrun_q <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (rx_done),
        .w_data (w_word),
        .rd     (host.rd_uart),
        .r_data (host.r_data),
        .empty  (host.rx_empty),
        .full   (fifo_full)
    );

    assign host.rx_full     = fifo_full;
    assign host.frame_err   = frame_err_q;
    assign host.overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign host.parity_err  = parity_err_q;
`else
    assign host.parity_err  = 1'b0;
`endif

endmodule
